// File: rtl/sram_like_arbiter_pkg.sv
// Shared sram-like bus definitions: FSM state encodings, owner codes, default widths.
package sram_like_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_like_arbiter_rr_arb2.sv
// Two-input round-robin grant; a tie goes to the source opposite the last grant.
module rr_arb2
  import sram_like_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   en_i,
  input  logic   req_inst_i,
  input  logic   req_data_i,
  output logic   gnt_vld_c_o,
  output owner_e gnt_own_c_o
);

  owner_e last_q;
  owner_e last_d;

  always_comb begin
    gnt_vld_c_o = 1'b0;
    gnt_own_c_o = OWN_INST;
    if (en_i) begin
      gnt_vld_c_o = req_inst_i | req_data_i;
      if (req_inst_i && req_data_i) begin
        gnt_own_c_o = (last_q == OWN_INST) ? OWN_DATA : OWN_INST;
      end else if (req_data_i) begin
        gnt_own_c_o = OWN_DATA;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_vld_c_o) begin
      last_d = gnt_own_c_o;
    end
  end

  // Reset to INST so the first tie after reset is won by DATA.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_q <= OWN_INST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the core's instruction and data sram-like ports onto one memory bus,
// one transaction outstanding at a time.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_data_ok
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                gnt_vld;
  owner_e              gnt_own;
  logic                rsp_vld;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .resetn      (resetn),
    .en_i        ((state_q == ST_IDLE) && resetn),
    .req_inst_i  (inst_req),
    .req_data_i  (data_req),
    .gnt_vld_c_o (gnt_vld),
    .gnt_own_c_o (gnt_own)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_vld)     state_d = ST_ADDR;
      ST_ADDR: if (mem_addr_ok) state_d = ST_DATA;
      ST_DATA: if (mem_data_ok) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Request capture on grant; instruction fetches are reads with no strobes or data.
  always_comb begin
    owner_d = owner_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (gnt_vld) begin
      owner_d = gnt_own;
      if (gnt_own == OWN_DATA) begin
        wr_d    = data_wr;
        wstrb_d = data_wstrb;
        addr_d  = data_addr;
        wdata_d = data_wdata;
      end else begin
        wr_d    = 1'b0;
        wstrb_d = '0;
        addr_d  = inst_addr;
        wdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner_q <= OWN_INST;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_wr    = wr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // mem_req depends on state only, so memory handshakes never loop back into it.
  always_comb begin
    mem_req      = (state_q == ST_ADDR);
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    rsp_vld      = resetn && (state_q == ST_DATA) && mem_data_ok;
    if (gnt_vld) begin
      inst_addr_ok = (gnt_own == OWN_INST);
      data_addr_ok = (gnt_own == OWN_DATA);
    end
    if (rsp_vld) begin
      if (owner_q == OWN_DATA) begin
        data_data_ok = 1'b1;
        data_rdata   = mem_rdata;
      end else begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: transaction table plus reset/spurious-response sequences.
module tb_sram_like_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic          data_req;
  logic          data_wr;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic          mem_req;
  logic          mem_wr;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok;
  logic [DW-1:0] mem_rdata;
  logic          mem_data_ok;

  always #5 clk = ~clk;

  sram_like_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_rdata    (mem_rdata),
    .mem_data_ok  (mem_data_ok)
  );

  typedef struct {
    logic          ireq;
    logic          dreq;
    logic [AW-1:0] iaddr;
    logic          dwr;
    logic [SW-1:0] dstrb;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    int            addr_wait;
    logic [DW-1:0] mrdata;
    logic          exp_own;   // 0 = inst, 1 = data
    logic          exp_wr;
    logic [SW-1:0] exp_strb;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic          own;
    logic          rd;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    step();
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata[26:0]}, 64'd0);
    chk("rst_oks", 64'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 64'd0);
    chk("rst_rdata", 64'({inst_rdata, data_rdata}), 64'd0);
    sb.delete();
    step();
    resetn = 1'b1;
  endtask

  // One transaction from an IDLE cycle: grant, ADDR (with optional backpressure), DATA.
  task automatic run_vec(input vec_t v);
    logic [1:0] exp_oh;
    exp_t       e;
    exp_oh     = v.exp_own ? 2'b10 : 2'b01;
    inst_req   = v.ireq;
    data_req   = v.dreq;
    inst_addr  = v.iaddr;
    data_wr    = v.dwr;
    data_wstrb = v.dstrb;
    data_addr  = v.daddr;
    data_wdata = v.dwdata;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    @(negedge clk);
    chk("grant_addr_ok", 64'({data_addr_ok, inst_addr_ok}), 64'(exp_oh));
    chk("idle_mem_req", 64'(mem_req), 64'd0);
    sb.push_back('{own: v.exp_own, rd: !v.exp_wr, rdata: v.mrdata});
    step();
    for (int k = 0; k <= v.addr_wait; k++) begin
      mem_addr_ok = (k == v.addr_wait);
      @(negedge clk);
      chk("addr_mem_req", 64'(mem_req), 64'd1);
      chk("addr_mem_wr", 64'(mem_wr), 64'(v.exp_wr));
      chk("addr_mem_wstrb", 64'(mem_wstrb), 64'(v.exp_strb));
      chk("addr_mem_addr", 64'(mem_addr), 64'(v.exp_addr));
      chk("addr_mem_wdata", 64'(mem_wdata), 64'(v.exp_wdata));
      chk("addr_no_ok", 64'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 64'd0);
      step();
    end
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = v.mrdata;
    @(negedge clk);
    chk("data_mem_req", 64'(mem_req), 64'd0);
    chk("data_ok", 64'({data_data_ok, inst_data_ok}), 64'(exp_oh));
    chk("data_no_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'd0);
    if (inst_data_ok || data_data_ok) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=data_ok expected=no_response at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (e.rd) chk("rdata", 64'(e.own ? data_rdata : inst_rdata), 64'(e.rdata));
      end
    end
    step();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    //          ireq  dreq  iaddr          dwr   strb  daddr          dwdata        wt mrdata         own   wr    strb  addr           wdata
    vecs[0] = '{1'b1, 1'b0, 32'hBFC00000, 1'b0, 4'h0, 32'h00000000, 32'h00000000, 0, 32'h3C1D0001, 1'b0, 1'b0, 4'h0, 32'hBFC00000, 32'h00000000};
    vecs[1] = '{1'b0, 1'b1, 32'h00000000, 1'b1, 4'h3, 32'h80001004, 32'hDEADBEEF, 0, 32'h00000000, 1'b1, 1'b1, 4'h3, 32'h80001004, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'h00000000, 1'b0, 4'h0, 32'h80002000, 32'h00000000, 1, 32'h12345678, 1'b1, 1'b0, 4'h0, 32'h80002000, 32'h00000000};
    vecs[3] = '{1'b1, 1'b1, 32'hBFC00004, 1'b1, 4'hF, 32'h80004000, 32'h11112222, 5, 32'h24020001, 1'b0, 1'b0, 4'h0, 32'hBFC00004, 32'h00000000};
    vecs[4] = '{1'b1, 1'b1, 32'hBFC00008, 1'b1, 4'hC, 32'h80003008, 32'hCAFEF00D, 2, 32'h00000000, 1'b1, 1'b1, 4'hC, 32'h80003008, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b1, 32'h00000040, 1'b0, 4'h0, 32'h80005000, 32'h00000000, 0, 32'hA5A5A5A5, 1'b0, 1'b0, 4'h0, 32'h00000040, 32'h00000000};

    inst_addr  = '0;
    data_wr    = 1'b0;
    data_wstrb = '0;
    data_addr  = '0;
    data_wdata = '0;
    do_reset();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both sources held high after reset: DATA, INST, DATA, INST.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      r.ireq      = 1'b1;
      r.dreq      = 1'b1;
      r.iaddr     = 32'hBFC00100 + 32'(n * 4);
      r.dwr       = 1'b0;
      r.dstrb     = 4'h0;
      r.daddr     = 32'h80006000 + 32'(n * 4);
      r.dwdata    = 32'h0;
      r.addr_wait = n;
      r.mrdata    = 32'h50000000 + 32'(n);
      r.exp_own   = (n % 2 == 0);
      r.exp_wr    = 1'b0;
      r.exp_strb  = 4'h0;
      r.exp_addr  = r.exp_own ? r.daddr : r.iaddr;
      r.exp_wdata = 32'h0;
      run_vec(r);
    end
    inst_req = 1'b0;
    data_req = 1'b0;

    // Reset while in DATA; the late memory response must be dropped.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00010;
    @(negedge clk);
    chk("mid_grant", 64'(inst_addr_ok), 64'd1);
    step();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("mid_addr_req", 64'(mem_req), 64'd1);
    step();
    mem_addr_ok = 1'b0;
    resetn      = 1'b0;
    @(negedge clk);
    chk("mid_in_data_req", 64'(mem_req), 64'd0);
    sb.delete();
    step();
    resetn      = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h77777777;
    @(negedge clk);
    chk("late_rsp_data_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);
    chk("late_rsp_rdata", 64'(inst_rdata), 64'd0);
    chk("late_rsp_mem_req", 64'(mem_req), 64'd0);
    chk("late_rsp_mem_addr", 64'(mem_addr), 64'd0);
    step();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'(mem_req), 64'd0);
    step();

    // Spurious memory handshakes while IDLE.
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h99999999;
    @(negedge clk);
    chk("spur_data_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);
    chk("spur_mem_req", 64'(mem_req), 64'd0);
    step();
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("spur_addr_ok_req", 64'(mem_req), 64'd0);
    chk("spur_addr_ok_oks", 64'({inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}), 64'd0);
    step();
    mem_addr_ok = 1'b0;

    // Still in IDLE with last grant reset to INST: a tie goes to DATA.
    r.ireq = 1'b1; r.dreq = 1'b1; r.iaddr = 32'hBFC00020;
    r.dwr = 1'b0; r.dstrb = 4'h0; r.daddr = 32'h80007000; r.dwdata = 32'h0;
    r.addr_wait = 0; r.mrdata = 32'h0BADF00D;
    r.exp_own = 1'b1; r.exp_wr = 1'b0; r.exp_strb = 4'h0;
    r.exp_addr = 32'h80007000; r.exp_wdata = 32'h0;
    run_vec(r);
    inst_req = 1'b0;
    data_req = 1'b0;

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Sits directly downstream of the CPU core's instruction and data sram-like ports.
- Merges the two ports onto one shared sram-like memory bus, with a single transaction outstanding.
- Handshake: req/addr_ok for the address phase, data_ok for the data phase.
- Lets the core run against a single-ported memory or bus bridge without changing datapath timing.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; DATA_W/8 write strobes.

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous reset, active-low
- inst_req  in  1  instruction read request
- inst_addr  in  ADDR_W  instruction address
- inst_rdata  out  DATA_W  instruction read data, valid with inst_data_ok
- inst_addr_ok  out  1  instruction request accepted (1-cycle pulse)
- inst_data_ok  out  1  instruction data returned (1-cycle pulse)
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  DATA_W/8  byte write strobes; ignored on read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_rdata  out  DATA_W  data read data, valid with data_data_ok
- data_addr_ok  out  1  data request accepted (1-cycle pulse)
- data_data_ok  out  1  data transaction complete (1-cycle pulse)
- mem_req  out  1  request to memory
- mem_wr  out  1  write flag
- mem_wstrb  out  DATA_W/8  byte strobes
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_addr_ok  in  1  memory accepted the request
- mem_rdata  in  DATA_W  memory read data
- mem_data_ok  in  1  memory response

Behaviour:
- Clock and reset: single clock; all state updates on the rising edge of clk.
- Reset: resetn=0 sampled at an edge forces the following.
  - state=IDLE and last_grant=INST.
  - mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata are all 0.
  - All addr_ok and data_ok outputs are 0; rdata outputs are 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE, request capture:
  - If any req is high, grant one source.
  - Pulse that source's addr_ok combinationally in the same cycle.
  - Latch its wr/wstrb/addr/wdata into the request registers (inst: wr=0, wstrb=0, wdata=0).
  - Record the owner and go to ADDR.
- Arbitration:
  - Only one requester: grant it.
  - Both requesting: grant the source opposite last_grant (round-robin); the first tie after reset goes to DATA.
  - last_grant updates on each grant.
- ADDR: mem_req=1 with the latched fields held stable. On mem_addr_ok=1, go to DATA.
- DATA:
  - mem_req=0.
  - On mem_data_ok=1, pulse owner_data_ok combinationally and drive owner_rdata=mem_rdata; next state IDLE.
  - On writes, data_data_ok still pulses; rdata content is don't-care.
- Non-owner outputs: the non-owner's addr_ok/data_ok stay 0 in every state.
- Acceptance rules:
  - No new request is accepted outside IDLE; pending reqs simply stay high.
  - The earliest new acceptance is the cycle after a data_ok.
- Minimum latency: req to data_ok is 2 cycles (IDLE grant, ADDR with addr_ok, DATA with data_ok).
- mem_data_ok in IDLE or ADDR is ignored. mem_addr_ok outside ADDR is ignored.
- Reset mid-transaction: the transaction is abandoned. No data_ok is generated for it, and a late mem_data_ok after reset is ignored.
- No combinational path from mem_addr_ok/mem_data_ok to mem_req.

Decomposition:
- Shared header cpu_bus_defs:
  - FSM state encodings (IDLE/ADDR/DATA).
  - Owner codes (OWN_INST=0, OWN_DATA=1).
  - Default ADDR_W/DATA_W.
- One natural sub-module: rr_arb2, a two-input round-robin grant with a last_grant register, reusable for a later bridge.
- Request registers and FSM stay in the top block.

Test Plan:
- Lone inst read: inst_req=1, addr=0xBFC00000; memory gives addr_ok next cycle, data_ok with rdata=0x3C1D0001 one cycle later -> inst_addr_ok in cycle 0, mem_req only in cycle 1, inst_data_ok and inst_rdata=0x3C1D0001 in cycle 2.
- Data write: data_wr=1, wstrb=0x3, addr=0x80001004, wdata=0xDEADBEEF -> mem_wr=1, mem_wstrb=0x3, fields stable through ADDR; data_data_ok pulses once.
- Simultaneous reqs held high for 4 transactions -> grant order DATA, INST, DATA, INST; exactly one addr_ok per IDLE cycle.
- Backpressure: mem_addr_ok held low 5 cycles -> mem_req and fields stay constant for 5 cycles; no new addr_ok to either source.
- Reset mid-operation: resetn=0 in DATA, then mem_data_ok arrives after release -> no data_ok pulse; state IDLE; mem_req=0.
- Spurious memory response: mem_data_ok=1 while IDLE -> both data_ok outputs stay 0; no state change.
